// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard, branch and SRAM wait arbitration,
// memory timeout trap and saturating performance counters. Optional macro: FORWARDING_EN.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             exe_mem_r_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             freeze_pc_if,
    output logic             bubble_id,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze_back,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic stall_src;
    logic err;
    logic mem_stall;
    logic data_stall;
    logic branch_flush;

`ifdef FORWARDING_EN
    // Only load-use hazards stall; the forwarding unit covers the rest.
    assign stall_src = hazard & exe_mem_r_en;
`else
    logic unused_exe_mem_r_en;
    assign unused_exe_mem_r_en = exe_mem_r_en;
    assign stall_src = hazard;
`endif

    // Priority: error > memory stall > branch flush > data stall.
    assign err          = (state == ERROR);
    assign mem_stall    = mem_req & ~sram_ready & ~err;
    assign branch_flush = branch_taken & ~mem_stall & ~err;
    assign data_stall   = stall_src & ~branch_taken & ~mem_stall & ~err;

    // Zero-latency control outputs, held low while reset is asserted.
    always_comb begin
        freeze_pc_if = 1'b0;
        bubble_id    = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        freeze_back  = 1'b0;
        if (rst) begin
            freeze_pc_if = data_stall | mem_stall | err;
            bubble_id    = data_stall;
            flush_if     = branch_flush;
            flush_id     = branch_flush;
            freeze_back  = mem_stall | err;
        end
    end

    // Wait-state FSM register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Wait-state FSM next state; timer counts consecutive not-ready cycles.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            RUN: begin
                if (mem_req && !sram_ready) begin
                    state_nxt = MEM_WAIT;
                    timer_nxt = TMR_W'(1);
                end else begin
                    timer_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (sram_ready || !mem_req) begin
                    state_nxt = RUN;
                    timer_nxt = '0;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ERROR;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
                timer_nxt = '0;
            end
        endcase
    end

    // Sticky trap flag, rises on the edge that enters ERROR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_timeout <= 1'b0;
        end else if (state_nxt == ERROR) begin
            mem_timeout <= 1'b1;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Performance counters; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, data_stall);
            flush_cnt <= sat_inc(flush_cnt, branch_flush);
            wait_cnt  <= sat_inc(wait_cnt, mem_stall);
        end
    end

endmodule
